// File: rtl/layer_pp_pkg.sv
// Shared constants and helpers for the conv-layer post-processing stage:
// default widths, lane-slice macros and the ReLU/round/saturate function.
`ifndef LAYER_PP_SLICE
`define LAYER_PP_SLICE(vec, i, w) vec[(w)*(i) +: (w)]
`endif

`ifndef LAYER_PP_LANE18
`define LAYER_PP_LANE18(vec, i) `LAYER_PP_SLICE(vec, i, 18)
`endif

package layer_pp_pkg;

    localparam int W_IN  = 18;
    localparam int W_ACC = 24;
    localparam int W_OUT = 8;

    // Operates on a 64-bit signed sum so it serves any lane width; callers truncate.
    function automatic logic [31:0] sat_relu_round(input logic signed [63:0] s,
                                                   input int unsigned shift,
                                                   input int unsigned w_out);
        logic signed [63:0] r;
        logic signed [63:0] max_v;
        r = (s < 0) ? 64'sd0 : s;
        if (shift > 0)
            r = (r + (64'sd1 <<< (shift - 1))) >>> shift;
        max_v = (64'sd1 <<< w_out) - 64'sd1;
        if (r > max_v)
            r = max_v;
        return r[31:0];
    endfunction

endpackage

// File: rtl/lane_postproc.sv
// One lane of the final-pass datapath: bias add at W_ACC+1 bits, then
// ReLU, round-half-up shift and unsigned saturation. Purely combinational.
module lane_postproc
    import layer_pp_pkg::*;
#(
    parameter int W_IN  = layer_pp_pkg::W_IN,
    parameter int W_ACC = layer_pp_pkg::W_ACC,
    parameter int SHIFT = 6,
    parameter int W_OUT = layer_pp_pkg::W_OUT
) (
    input  logic signed [W_ACC-1:0] acc_eff,
    input  logic signed [W_IN-1:0]  bias,
    output logic        [W_OUT-1:0] result
);

    // One extra bit so a full-scale accumulator plus full-scale bias cannot wrap.
    logic signed [W_ACC:0] s;

    assign s      = (W_ACC+1)'(acc_eff) + (W_ACC+1)'(bias);
    assign result = W_OUT'(sat_relu_round(64'(s), SHIFT, W_OUT));

endmodule

// File: rtl/layer_accum_bias_relu.sv
// Post-adder-tree stage: accumulates N_PASSES beats per lane, and on the final
// beat adds bias, requantizes and registers the result behind valid/ready.
module layer_accum_bias_relu
    import layer_pp_pkg::*;
#(
    parameter int N_ADDER_TREE = 16,
    parameter int W_IN         = layer_pp_pkg::W_IN,
    parameter int N_PASSES     = 9,
    parameter int W_ACC        = layer_pp_pkg::W_ACC,
    parameter int SHIFT        = 6,
    parameter int W_OUT        = layer_pp_pkg::W_OUT,
    localparam int PW          = (N_PASSES > 1) ? $clog2(N_PASSES) : 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [N_ADDER_TREE*W_IN-1:0]  in_data,
    input  logic [N_ADDER_TREE*W_IN-1:0]  bias,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [N_ADDER_TREE*W_OUT-1:0] out_data,
    output logic [PW-1:0]                 pass_idx
);

    if (N_PASSES < 1) begin : g_bad_passes
        $error("N_PASSES must be at least 1");
    end
    if (W_ACC < W_IN + $clog2(N_PASSES) + 1) begin : g_bad_wacc
        $error("W_ACC too narrow for W_IN partial sums over N_PASSES beats");
    end

    localparam logic [PW-1:0] LAST = PW'(N_PASSES - 1);

    logic                    final_beat;
    logic                    accept;
    logic signed [W_ACC-1:0] acc      [N_ADDER_TREE];
    logic signed [W_ACC-1:0] acc_next [N_ADDER_TREE];
    logic        [W_OUT-1:0] post     [N_ADDER_TREE];

    assign final_beat = (pass_idx == LAST);
    // Only the final beat can collide with an undrained output register.
    assign in_ready   = !final_beat || !out_valid || out_ready;
    assign accept     = in_valid && in_ready;

    for (genvar i = 0; i < N_ADDER_TREE; i++) begin : g_lane
        logic signed [W_IN-1:0]  lane_in;
        logic signed [W_IN-1:0]  lane_bias;
        logic signed [W_ACC-1:0] in_sext;

        assign lane_in   = `LAYER_PP_SLICE(in_data, i, W_IN);
        assign lane_bias = `LAYER_PP_SLICE(bias, i, W_IN);
        assign in_sext   = W_ACC'(lane_in);
        // Pass 0 restarts the group; with N_PASSES=1 pass_idx is always 0.
        assign acc_next[i] = (pass_idx == '0) ? in_sext : acc[i] + in_sext;

        lane_postproc #(
            .W_IN  (W_IN),
            .W_ACC (W_ACC),
            .SHIFT (SHIFT),
            .W_OUT (W_OUT)
        ) u_post (
            .acc_eff (acc_next[i]),
            .bias    (lane_bias),
            .result  (post[i])
        );
    end

    // NOTE: state uses <= so every lane updates from the same pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            pass_idx  <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            for (int i = 0; i < N_ADDER_TREE; i++)
                acc[i] <= '0;
        end else begin
            if (accept) begin
                for (int i = 0; i < N_ADDER_TREE; i++)
                    acc[i] <= acc_next[i];
                pass_idx <= final_beat ? '0 : pass_idx + PW'(1);
            end
            if (accept && final_beat) begin
                out_valid <= 1'b1;
                for (int i = 0; i < N_ADDER_TREE; i++)
                    out_data[W_OUT*i +: W_OUT] <= post[i];
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
